param_updown_counter: RTL

//   Parametrised up/down counter with load, a programmable terminal value, a

---
 rtl/param_updown_counter_pkg.sv | 11 +
 rtl/param_updown_counter_sva.sv | 114 +++++++++++
 rtl/param_updown_counter.sv | 119 +++++++++++
 3 files changed

// File: rtl/param_updown_counter_pkg.sv
// Shared types and helpers for the parametrised up/down counter.
package param_updown_counter_pkg;

    typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_e;

    // Callers zero-extend to 32 bits, so WIDTH is limited to 32.
    function automatic logic [31:0] clip(input logic [31:0] value, input logic [31:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/param_updown_counter_sva.sv
// Embedded checkers and covers for param_updown_counter.
// Compiled only when PARAM_UPDOWN_COUNTER_SVA_EN is defined.
`ifdef PARAM_UPDOWN_COUNTER_SVA_EN
module param_updown_counter_sva
    import param_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    input logic             load_n,
    input logic             ce,
    input logic             up_down,
    input logic             mode,
    input logic [WIDTH-1:0] term_val,
    input logic [WIDTH-1:0] data_load,
    input logic [WIDTH-1:0] count_out,
    input logic             zero,
    input logic             max_count,
    input logic             wrap_evt,
    input logic             ovf_sticky,
    input logic             unf_sticky,
    input logic             load_clip
);

    logic count_lt, count_nz, is_wrap;
    assign count_lt = count_out < term_val;
    assign count_nz = count_out != '0;
    assign is_wrap  = mode == CNT_WRAP;

    // The first edge after reset release still sees reset values.
    property p_reset_vals;
        @(posedge clk) disable iff (rst)
        $past(rst) |-> (count_out == '0) && !wrap_evt && !ovf_sticky && !unf_sticky && !load_clip;
    endproperty

    property p_load;
        @(posedge clk) disable iff (rst)
        (!$past(rst) && !$past(load_n)) |->
            (count_out == WIDTH'(clip(32'($past(data_load)), 32'($past(term_val)))))
            && (load_clip == ($past(data_load) > $past(term_val)));
    endproperty

    property p_hold;
        @(posedge clk) disable iff (rst)
        (!$past(rst) && $past(load_n) && !$past(ce)) |->
            $stable(count_out) && !wrap_evt && !load_clip;
    endproperty

    property p_up_step;
        @(posedge clk) disable iff (rst)
        (!$past(rst) && $past(load_n && ce && up_down && count_lt)) |->
            count_out == WIDTH'($past(count_out) + 1'b1);
    endproperty

    property p_up_wrap;
        @(posedge clk) disable iff (rst)
        (!$past(rst) && $past(load_n && ce && up_down && !count_lt && is_wrap)) |->
            (count_out == '0) && wrap_evt;
    endproperty

    property p_up_sat;
        @(posedge clk) disable iff (rst)
        (!$past(rst) && $past(load_n && ce && up_down && !count_lt && !is_wrap)) |->
            (count_out == $past(term_val)) && ovf_sticky;
    endproperty

    property p_down_step;
        @(posedge clk) disable iff (rst)
        (!$past(rst) && $past(load_n && ce && !up_down && count_nz)) |->
            count_out == WIDTH'($past(count_out) - 1'b1);
    endproperty

    property p_down_wrap;
        @(posedge clk) disable iff (rst)
        (!$past(rst) && $past(load_n && ce && !up_down && !count_nz && is_wrap)) |->
            (count_out == $past(term_val)) && wrap_evt;
    endproperty

    property p_down_sat;
        @(posedge clk) disable iff (rst)
        (!$past(rst) && $past(load_n && ce && !up_down && !count_nz && !is_wrap)) |->
            (count_out == '0) && unf_sticky;
    endproperty

    property p_flags;
        @(posedge clk) disable iff (rst)
        (zero == (count_out == '0)) && (max_count == (count_out == term_val));
    endproperty

    a_reset_vals: assert property (p_reset_vals);
    a_load:       assert property (p_load);
    a_hold:       assert property (p_hold);
    a_up_step:    assert property (p_up_step);
    a_up_wrap:    assert property (p_up_wrap);
    a_up_sat:     assert property (p_up_sat);
    a_down_step:  assert property (p_down_step);
    a_down_wrap:  assert property (p_down_wrap);
    a_down_sat:   assert property (p_down_sat);
    a_flags:      assert property (p_flags);

    c_reset_vals: cover property (p_reset_vals);
    c_load:       cover property (p_load);
    c_hold:       cover property (p_hold);
    c_up_step:    cover property (p_up_step);
    c_up_wrap:    cover property (p_up_wrap);
    c_up_sat:     cover property (p_up_sat);
    c_down_step:  cover property (p_down_step);
    c_down_wrap:  cover property (p_down_wrap);
    c_down_sat:   cover property (p_down_sat);
    c_flags:      cover property (p_flags);

endmodule
`endif

// File: rtl/param_updown_counter.sv
// Up/down counter with load, programmable terminal value, wrap/saturate mode and status flags.
// Define PARAM_UPDOWN_COUNTER_SVA_EN to bind in the embedded checkers.
module param_updown_counter
    import param_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_n,
    input  logic             ce,
    input  logic             up_down,
    input  logic             mode,
    input  logic [WIDTH-1:0] term_val,
    input  logic [WIDTH-1:0] data_load,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count_out,
    output logic             zero,
    output logic             max_count,
    output logic             wrap_evt,
    output logic             ovf_sticky,
    output logic             unf_sticky,
    output logic             load_clip
);

    logic [WIDTH-1:0] count_d, count_q;
    logic             wrap_d, wrap_q;
    logic             clip_d, clip_q;
    logic             ovf_d, ovf_q;
    logic             unf_d, unf_q;
    logic             ovf_set, unf_set;
    cnt_mode_e        mode_e;

    assign mode_e = cnt_mode_e'(mode);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        clip_d  = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (!load_n) begin
            count_d = WIDTH'(clip(32'(data_load), 32'(term_val)));
            clip_d  = data_load > term_val;
        end else if (ce) begin
            if (up_down) begin
                // >= also catches a count left above a freshly lowered term_val.
                if (count_q < term_val) begin
                    count_d = count_q + WIDTH'(1);
                end else if (mode_e == CNT_WRAP) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = term_val;
                    ovf_set = 1'b1;
                end
            end else begin
                if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end else if (mode_e == CNT_WRAP) begin
                    count_d = term_val;
                    wrap_d  = 1'b1;
                end else begin
                    unf_set = 1'b1;
                end
            end
        end
        // Set beats clear when both happen on the same edge.
        ovf_d = ovf_set | (ovf_q & ~clr_flags);
        unf_d = unf_set | (unf_q & ~clr_flags);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            clip_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            clip_q  <= clip_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count_out  = count_q;
    assign zero       = count_q == '0;
    assign max_count  = count_q == term_val;
    assign wrap_evt   = wrap_q;
    assign load_clip  = clip_q;
    assign ovf_sticky = ovf_q;
    assign unf_sticky = unf_q;

`ifdef PARAM_UPDOWN_COUNTER_SVA_EN
    param_updown_counter_sva #(
        .WIDTH(WIDTH)
    ) u_sva (
        .clk       (clk),
        .rst       (rst),
        .load_n    (load_n),
        .ce        (ce),
        .up_down   (up_down),
        .mode      (mode),
        .term_val  (term_val),
        .data_load (data_load),
        .count_out (count_out),
        .zero      (zero),
        .max_count (max_count),
        .wrap_evt  (wrap_evt),
        .ovf_sticky(ovf_sticky),
        .unf_sticky(unf_sticky),
        .load_clip (load_clip)
    );
`endif

endmodule
